// File: rtl/stack_unit_pkg.sv
// Shared CPU package: stack geometry defaults, the pointer-width helper and the
// stack controller's operation encoding.
package stack_unit_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 8;

  // The pointer holds a count of 0..DEPTH, so it needs one bit beyond the index width.
  function automatic int sp_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Operation decoded from the push/pop/tos strobes for one cycle.
  typedef enum logic [2:0] {
    OP_IDLE     = 3'd0,
    OP_PUSH     = 3'd1,
    OP_POP      = 3'd2,
    OP_TOS      = 3'd3,
    OP_REPLACE  = 3'd4,
    OP_TOS_PUSH = 3'd5
  } stack_op_e;

endpackage

// File: rtl/stack_mem.sv
// Stack storage: DEPTH x DATA_W register file with one synchronous write port,
// one asynchronous read port and asynchronous clear.
module stack_mem
  import stack_unit_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Clear every entry on reset, otherwise write one entry when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/stack_unit.sv
// Hardware stack: push/pop/tos control, entry count pointer, registered read
// output and sticky overflow/underflow flags around a stack_mem register file.
module stack_unit
  import stack_unit_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int SPW   = sp_width(DEPTH),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              tos,
  input  logic              MtoS,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] stack_out,
  output logic [SPW-1:0]    sp,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  logic [SPW-1:0]    r_sp;
  logic [DATA_W-1:0] r_stack_out;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_empty;
  logic              w_full;
  logic [DATA_W-1:0] w_src;
  logic [DATA_W-1:0] w_top;
  logic [SPW-1:0]    w_sp_m1;
  logic [AW-1:0]     w_top_idx;
  stack_op_e         w_op;

  logic              w_push_req;
  logic              w_we;
  logic [AW-1:0]     w_waddr;
  logic [SPW-1:0]    w_sp_nxt;
  logic              w_so_ld;
  logic [DATA_W-1:0] w_so_val;
  logic              w_ovf_set;
  logic              w_und_set;

  assign w_empty   = (r_sp == '0);
  assign w_full    = (r_sp == SPW'(DEPTH));
  assign w_src     = MtoS ? mem_data : alu_res;
  assign w_sp_m1   = r_sp - 1'b1;
  // Only meaningful when not empty; the read is ignored otherwise.
  assign w_top_idx = w_sp_m1[AW-1:0];

  stack_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_src),
    .i_raddr (w_top_idx),
    .o_rdata (w_top)
  );

  // Classify the strobes: pop dominates tos, and pop with push replaces the top.
  always_comb begin
    w_op = OP_IDLE;
    if (pop) begin
      w_op = push ? OP_REPLACE : OP_POP;
    end else if (tos) begin
      w_op = push ? OP_TOS_PUSH : OP_TOS;
    end else if (push) begin
      w_op = OP_PUSH;
    end
  end

  // Decide this cycle's read, write, pointer move and error flags.
  always_comb begin
    w_push_req = 1'b0;
    w_we       = 1'b0;
    w_waddr    = r_sp[AW-1:0];
    w_sp_nxt   = r_sp;
    w_so_ld    = 1'b0;
    w_so_val   = w_top;
    w_ovf_set  = 1'b0;
    w_und_set  = 1'b0;

    case (w_op)
      OP_PUSH: w_push_req = 1'b1;
      OP_POP: begin
        w_so_ld = 1'b1;
        if (w_empty) begin
          w_so_val  = '0;
          w_und_set = 1'b1;
        end else begin
          w_sp_nxt = w_sp_m1;
        end
      end
      OP_TOS, OP_TOS_PUSH: begin
        // Read sees the top as it was before any push in the same cycle.
        w_so_ld    = 1'b1;
        w_push_req = (w_op == OP_TOS_PUSH);
        if (w_empty) begin
          w_so_val  = '0;
          w_und_set = 1'b1;
        end
      end
      OP_REPLACE: begin
        if (w_empty) begin
          // Nothing to replace: the push still happens, the pop is an error.
          w_und_set  = 1'b1;
          w_push_req = 1'b1;
        end else begin
          w_so_ld = 1'b1;
          w_we    = 1'b1;
          w_waddr = w_top_idx;
        end
      end
      default: ;
    endcase

    if (w_push_req) begin
      if (w_full) begin
        w_ovf_set = 1'b1;
      end else begin
        w_we     = 1'b1;
        w_waddr  = r_sp[AW-1:0];
        w_sp_nxt = r_sp + 1'b1;
      end
    end
  end

  // Pointer, read register and sticky flags; flags clear only on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp        <= '0;
      r_stack_out <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_sp <= w_sp_nxt;
      if (w_so_ld) r_stack_out <= w_so_val;
      if (w_ovf_set) r_overflow <= 1'b1;
      if (w_und_set) r_underflow <= 1'b1;
    end
  end

  assign stack_out = r_stack_out;
  assign sp        = r_sp;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: directed scenarios with fixed expected
// values, then randomized traffic compared against a queue-based stack model.
module tb_stack_unit;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int SPW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              push = 1'b0, pop = 1'b0, tos = 1'b0, MtoS = 1'b0;
  logic [DATA_W-1:0] mem_data = '0, alu_res = '0;
  logic [DATA_W-1:0] stack_out;
  logic [SPW-1:0]    sp;
  logic              empty, full, overflow, underflow;

  stack_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .tos       (tos),
    .MtoS      (MtoS),
    .mem_data  (mem_data),
    .alu_res   (alu_res),
    .stack_out (stack_out),
    .sp        (sp),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] m_stk[$];
  logic [DATA_W-1:0] m_out;
  logic              m_ovf, m_und;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_stk.delete();
    m_out = '0;
    m_ovf = 1'b0;
    m_und = 1'b0;
  endfunction

  // One clock edge of stack behaviour, stated directly on a queue.
  function automatic void model_step(input bit pu, po, to, mt,
                                     input logic [DATA_W-1:0] md, ar);
    logic [DATA_W-1:0] src;
    src = mt ? md : ar;
    if (po) begin
      if (m_stk.size() == 0) begin
        m_und = 1'b1;
        if (pu) m_stk.push_back(src);
        else    m_out = '0;
      end else if (pu) begin
        m_out = m_stk[m_stk.size()-1];
        m_stk[m_stk.size()-1] = src;
      end else begin
        m_out = m_stk.pop_back();
      end
    end else begin
      if (to) begin
        if (m_stk.size() == 0) begin
          m_out = '0;
          m_und = 1'b1;
        end else begin
          m_out = m_stk[m_stk.size()-1];
        end
      end
      if (pu) begin
        if (m_stk.size() == DEPTH) m_ovf = 1'b1;
        else                       m_stk.push_back(src);
      end
    end
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".stack_out"}, 32'(stack_out), 32'(m_out));
    chk({tag, ".sp"},        32'(sp),        32'(m_stk.size()));
    chk({tag, ".empty"},     32'(empty),     32'(m_stk.size() == 0));
    chk({tag, ".full"},      32'(full),      32'(m_stk.size() == DEPTH));
    chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(m_und));
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    push = 1'b0; pop = 1'b0; tos = 1'b0;
    model_reset();
    #1;
    check_model("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive one cycle of strobes, advance the model at the edge, check after it.
  task automatic step(input string tag, input bit pu, po, to, mt,
                      input logic [DATA_W-1:0] md, ar);
    @(negedge clk);
    push = pu; pop = po; tos = to; MtoS = mt;
    mem_data = md; alu_res = ar;
    @(posedge clk);
    model_step(pu, po, to, mt, md, ar);
    #1;
    check_model(tag);
  endtask

  task automatic idle();
    @(negedge clk);
    push = 1'b0; pop = 1'b0; tos = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    rst = 1'b1;
    #12;
    rst = 1'b0;

    // Three ALU pushes then a peek.
    do_reset();
    step("push11", 1, 0, 0, 0, 8'h00, 8'h11);
    step("push22", 1, 0, 0, 0, 8'h00, 8'h22);
    step("push33", 1, 0, 0, 0, 8'h00, 8'h33);
    chk("three_push_sp", 32'(sp), 32'd3);
    step("tos33", 0, 0, 1, 0, 8'h00, 8'h00);
    chk("tos_value", 32'(stack_out), 32'h33);
    chk("tos_sp", 32'(sp), 32'd3);

    // Drain in LIFO order.
    step("pop1", 0, 1, 0, 0, 8'h00, 8'h00);
    chk("pop1_value", 32'(stack_out), 32'h33);
    step("pop2", 0, 1, 0, 0, 8'h00, 8'h00);
    chk("pop2_value", 32'(stack_out), 32'h22);
    step("pop3", 0, 1, 0, 0, 8'h00, 8'h00);
    chk("pop3_value", 32'(stack_out), 32'h11);
    chk("drain_sp", 32'(sp), 32'd0);
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_underflow", 32'(underflow), 32'd0);

    // Fill from memory data, then overflow.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      step("fill", 1, 0, 0, 1, 8'(8'hA0 + i), 8'($urandom_range(0, 255)));
    end
    chk("fill_full", 32'(full), 32'd1);
    step("push_full", 1, 0, 0, 1, 8'hFF, 8'h00);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_sp", 32'(sp), 32'd8);
    step("pop_after_ovf", 0, 1, 0, 0, 8'h00, 8'h00);
    chk("pop_after_ovf_value", 32'(stack_out), 32'hA7);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Underflow on empty pop, sticky across a later push.
    do_reset();
    step("pop_empty", 0, 1, 0, 0, 8'h00, 8'h00);
    chk("und_value", 32'(stack_out), 32'h00);
    chk("und_flag", 32'(underflow), 32'd1);
    chk("und_sp", 32'(sp), 32'd0);
    step("push05", 1, 0, 0, 0, 8'h00, 8'h05);
    chk("und_push_sp", 32'(sp), 32'd1);
    chk("und_sticky", 32'(underflow), 32'd1);

    // Replace top with simultaneous push and pop.
    do_reset();
    step("push04", 1, 0, 0, 0, 8'h00, 8'h04);
    step("push09", 1, 0, 0, 0, 8'h00, 8'h09);
    step("replace", 1, 1, 0, 0, 8'h00, 8'h0D);
    chk("replace_value", 32'(stack_out), 32'h09);
    chk("replace_sp", 32'(sp), 32'd2);
    step("tos_after_replace", 0, 0, 1, 0, 8'h00, 8'h00);
    chk("replace_tos", 32'(stack_out), 32'h0D);

    // tos with push reads the old top, then pushes.
    step("tos_push", 1, 0, 1, 1, 8'h5A, 8'h00);
    chk("tos_push_value", 32'(stack_out), 32'h0D);
    chk("tos_push_sp", 32'(sp), 32'd3);

    // Reset pulsed between edges with a push pending at sp=5.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step("pre_rst_push", 1, 0, 0, 0, 8'h00, 8'(8'h30 + i));
    end
    step("pre_rst_tos", 0, 0, 1, 0, 8'h00, 8'h00);
    chk("pre_rst_sp", 32'(sp), 32'd5);
    @(negedge clk);
    push = 1'b1; alu_res = 8'hEE;
    #1 rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_sp", 32'(sp), 32'd0);
    chk("midrst_out", 32'(stack_out), 32'd0);
    chk("midrst_ovf", 32'(overflow), 32'd0);
    chk("midrst_und", 32'(underflow), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    rst = 1'b0;
    push = 1'b0;
    step("tos_after_rst", 0, 0, 1, 0, 8'h00, 8'h00);
    chk("tos_after_rst_und", 32'(underflow), 32'd1);
    chk("tos_after_rst_out", 32'(stack_out), 32'd0);

    // Randomized traffic against the queue model, with occasional resets.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bit pu, po, to, mt;
      if ($urandom_range(0, 99) == 0) do_reset();
      pu = ($urandom_range(0, 99) < 50);
      po = ($urandom_range(0, 99) < 30);
      to = ($urandom_range(0, 99) < 20);
      mt = $urandom_range(0, 1) == 1;
      step("rand", pu, po, to, mt, 8'($urandom), 8'($urandom));
    end
    idle();

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
